output_deskew_fifo: RTL and testbench

//  Receive end of the systolic array. Column results leave the PE array skewed: lane i of a row arrives i enabled cycles after lane 0.
//  Re-aligns lanes with an inverse triangle of delays: lane i is held N-1-i enabled cycles.

---
 rtl/sa_pkg.sv | 19 +
 rtl/inverse_triangle_shifter_array.sv | 43 ++++
 rtl/sa_shift_cell.sv | 37 +++
 rtl/output_deskew_fifo.sv | 117 +++++++++++
 tb/tb_output_deskew_fifo.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/sa_pkg.sv
// Constants and lane-slice helpers shared by the systolic array edge logic (input skew and output deskew).
// Lane i of a row word sits at [lane_msb(i) -: DATA_WIDTH].
package sa_pkg;

  localparam int N          = 4;
  localparam int DATA_WIDTH = 16;
  localparam int ROW_W      = N * DATA_WIDTH;
  localparam int FIFO_DEPTH = 8;
  localparam int TILE_ROWS  = 4;

  function automatic int lane_msb(input int i);
    return DATA_WIDTH * (i + 1) - 1;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] lane_get(input logic [ROW_W-1:0] row, input int i);
    return row[lane_msb(i) -: DATA_WIDTH];
  endfunction

endpackage

// File: rtl/inverse_triangle_shifter_array.sv
// Inverse-triangle deskew: lane i is held N-1-i enabled cycles, the row-start valid N-1 cycles.
module inverse_triangle_shifter_array
  import sa_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             vld_i,
  input  logic [ROW_W-1:0] dat_i,
  output logic             vld_o,
  output logic [ROW_W-1:0] dat_o
);

  for (genvar i = 0; i < N; i++) begin : g_lane
    if (i == N - 1) begin : g_pass
      // Last lane arrives already aligned with the delayed valid
      assign dat_o[lane_msb(i) -: DATA_WIDTH] = dat_i[lane_msb(i) -: DATA_WIDTH];
    end else begin : g_dly
      sa_shift_cell #(
        .WIDTH  (DATA_WIDTH),
        .STAGES (N - 1 - i)
      ) u_cell (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en_i  (en_i),
        .d_i   (dat_i[lane_msb(i) -: DATA_WIDTH]),
        .q_o   (dat_o[lane_msb(i) -: DATA_WIDTH])
      );
    end
  end

  sa_shift_cell #(
    .WIDTH  (1),
    .STAGES (N - 1)
  ) u_vld (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (en_i),
    .d_i   (vld_i),
    .q_o   (vld_o)
  );

endmodule

// File: rtl/sa_shift_cell.sv
// Enable-gated shift register of STAGES stages (STAGES >= 1); all stages hold while en_i is low.
module sa_shift_cell #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [STAGES];
  logic [WIDTH-1:0] stage_d [STAGES];

  always_comb begin
    stage_d[0] = d_i;
    for (int s = 1; s < STAGES; s++) begin
      stage_d[s] = stage_q[s-1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int s = 0; s < STAGES; s++) begin
        stage_q[s] <= '0;
      end
    end else if (en_i) begin
      for (int s = 0; s < STAGES; s++) begin
        stage_q[s] <= stage_d[s];
      end
    end
  end

  assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/output_deskew_fifo.sv
// Re-aligns skewed PE-array lanes and buffers aligned rows in a FIFO for a valid/ready consumer.
// Define OUTPUT_LAST_EN to tag the last row of each TILE_ROWS-row tile on out_last.
module output_deskew_fifo
  import sa_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             in_valid,
  input  logic [ROW_W-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ROW_W-1:0] out_data,
  output logic             out_last,
  output logic             almost_full,
  output logic             overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic             dsk_vld;
  logic [ROW_W-1:0] dsk_dat;

  inverse_triangle_shifter_array u_deskew (
    .clk_i (clk),
    .rst_i (rst),
    .en_i  (enable),
    .vld_i (in_valid),
    .dat_i (in_data),
    .vld_o (dsk_vld),
    .dat_o (dsk_dat)
  );

  logic [ROW_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             push_req, push, pop, full;

  always_comb begin
    full     = (count_q == CNT_W'(FIFO_DEPTH));
    pop      = out_valid & out_ready;
    push_req = enable & dsk_vld;
    // A full FIFO still takes the row when the head leaves on the same edge
    push     = push_req & (~full | pop);
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    count_d  = count_q;
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_W'(1);
    end
    overflow_d = overflow_q | (push_req & full & ~pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      for (int e = 0; e < FIFO_DEPTH; e++) begin
        mem_q[e] <= '0;
      end
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      if (push) begin
        mem_q[wr_ptr_q] <= dsk_dat;
      end
    end
  end

  assign out_valid   = (count_q != '0);
  assign out_data    = mem_q[rd_ptr_q];
  assign almost_full = (count_q >= CNT_W'(FIFO_DEPTH - N));
  assign overflow    = overflow_q;

`ifdef OUTPUT_LAST_EN
  localparam int TILE_W = (TILE_ROWS > 1) ? $clog2(TILE_ROWS) : 1;

  logic [TILE_W-1:0]     tile_q, tile_d;
  logic [FIFO_DEPTH-1:0] last_q;
  logic                  tile_end;

  // Dropped rows never reach push, so they do not advance the tile position
  always_comb begin
    tile_end = (tile_q == TILE_W'(TILE_ROWS - 1));
    tile_d   = tile_q;
    if (push) begin
      tile_d = tile_end ? '0 : tile_q + TILE_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tile_q <= '0;
      last_q <= '0;
    end else begin
      tile_q <= tile_d;
      if (push) begin
        last_q[wr_ptr_q] <= tile_end;
      end
    end
  end

  assign out_last = out_valid & last_q[rd_ptr_q];
`else
  assign out_last = 1'b0;
`endif

endmodule

// File: tb/tb_output_deskew_fifo.sv
// Row-level reference model (input history + queue FIFO) checked every cycle, plus directed literal checks.
module tb_output_deskew_fifo;
  import sa_pkg::*;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             enable = 1'b0;
  logic             in_valid = 1'b0;
  logic [ROW_W-1:0] in_data = '0;
  logic             out_ready = 1'b0;
  logic             out_valid;
  logic [ROW_W-1:0] out_data;
  logic             out_last;
  logic             almost_full;
  logic             overflow;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  output_deskew_fifo dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_last    (out_last),
    .almost_full (almost_full),
    .overflow    (overflow)
  );

  task automatic check(input string name, input logic [ROW_W-1:0] act, input logic [ROW_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic             last;
    logic [ROW_W-1:0] dat;
  } ent_t;

  logic [ROW_W-1:0] hdat[$];
  bit               hvld[$];
  ent_t             mq[$];
  bit               movf = 1'b0;
  int               mtile = 0;

  always @(posedge clk) begin
    bit               push_req, pop, full;
    ent_t             e;
    int               k;
    logic [ROW_W-1:0] src;
    if (rst) begin
      hdat.delete();
      hvld.delete();
      mq.delete();
      movf  = 1'b0;
      mtile = 0;
    end else begin
      push_req = 1'b0;
      e        = '0;
      if (enable) begin
        hdat.push_back(in_data);
        hvld.push_back(in_valid);
        k = hdat.size() - 1;
        // Row whose lane 0 entered N-1 enabled cycles ago is now complete
        if (k >= N - 1 && hvld[k-(N-1)]) begin
          push_req = 1'b1;
          for (int i = 0; i < N; i++) begin
            src = hdat[k-(N-1-i)];
            e.dat[i*DATA_WIDTH +: DATA_WIDTH] = src[i*DATA_WIDTH +: DATA_WIDTH];
          end
        end
      end
      pop  = (mq.size() > 0) && out_ready;
      full = (mq.size() == FIFO_DEPTH);
      if (pop) void'(mq.pop_front());
      if (push_req) begin
        if (!full || pop) begin
`ifdef OUTPUT_LAST_EN
          e.last = (mtile == TILE_ROWS - 1);
`else
          e.last = 1'b0;
`endif
          mq.push_back(e);
          mtile = (mtile + 1) % TILE_ROWS;
        end else begin
          movf = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("out_valid", out_valid, (mq.size() > 0) ? 1 : 0);
      check("almost_full", almost_full, (mq.size() >= FIFO_DEPTH - N) ? 1 : 0);
      check("overflow", overflow, movf);
      if (mq.size() > 0) begin
        check("out_data", out_data, mq[0].dat);
        check("out_last", out_last, mq[0].last);
      end else begin
        check("out_last_idle", out_last, 0);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(negedge clk);
  endtask

  function automatic logic [DATA_WIDTH-1:0] val(input int base, input int r, input int i);
    return DATA_WIDTH'(base + r * 16 + i);
  endfunction

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) begin
      enable = 1'b1; in_valid = 1'b0; in_data = '0;
      step();
    end
  endtask

  // Drives nrows skewed rows; lane i of row r appears i cycles after lane 0.
  task automatic drive_rows(input int nrows, input int base, input int stall_at,
                            input int stall_len, input int rdy_at);
    logic [ROW_W-1:0] d;
    for (int c = 0; c <= nrows + N - 2; c++) begin
      if (c == rdy_at) out_ready = 1'b1;
      if (c == stall_at) begin
        for (int s = 0; s < stall_len; s++) begin
          enable = 1'b0; in_valid = 1'b1; in_data = {N{16'hDEAD}};
          step();
        end
      end
      d = '0;
      for (int i = 0; i < N; i++) begin
        if (c - i >= 0 && c - i < nrows) d[i*DATA_WIDTH +: DATA_WIDTH] = val(base, c - i, i);
      end
      enable = 1'b1; in_valid = (c < nrows); in_data = d;
      step();
    end
    in_valid = 1'b0; in_data = '0;
  endtask

  task automatic drain(output int npop, output logic [7:0] mask);
    npop = 0; mask = '0;
    enable = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (!out_valid) break;
      if (npop < 8) mask[npop] = out_last;
      npop++;
      step();
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b1; enable = 1'b0; in_valid = 1'b0; in_data = '0;
    step();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int         n;
    logic [7:0] m;

    repeat (2) step();
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_last", out_last, 0);
    check("rst_almost_full", almost_full, 0);
    check("rst_overflow", overflow, 0);
    rst = 1'b0;
    chk_en = 1'b1;

    // T1 latency
    out_ready = 1'b1;
    drive_rows(1, 'h10, -1, 0, -1);
    check("t1_valid_at_t4", out_valid, 1);
    check("t1_data", out_data, 64'h0013_0012_0011_0010);
    step();
    check("t1_one_cycle", out_valid, 0);

    // T2 stream
    drive_rows(8, 0, -1, 0, -1);
    check("t2_row8_data", out_data, 64'h0073_0072_0071_0070);
    check("t2_overflow", overflow, 0);
    step();
    check("t2_empty", out_valid, 0);

    // T3 stall mid-row
    drive_rows(1, 'h20, 2, 3, -1);
    check("t3_valid", out_valid, 1);
    check("t3_data", out_data, 64'h0023_0022_0021_0020);
    step();

    // T4 backpressure and overflow
    out_ready = 1'b0;
    drive_rows(3, 'h100, -1, 0, -1);
    check("t4_af_count3", almost_full, 0);
    drive_rows(1, 'h130, -1, 0, -1);
    check("t4_af_count4", almost_full, 1);
    check("t4_no_ovf_yet", overflow, 0);
    drive_rows(5, 'h140, -1, 0, -1);
    check("t4_overflow", overflow, 1);
    check("t4_head", out_data, 64'h0103_0102_0101_0100);
    drain(n, m);
    check("t4_drain_count", n, 8);
    check("t4_ovf_sticky", overflow, 1);

    // T6 reset with buffered rows and a partial row in flight
    out_ready = 1'b0;
    drive_rows(2, 'h600, -1, 0, -1);
    enable = 1'b1; in_valid = 1'b1; in_data = 64'h0000_0000_0000_0700;
    step();
    in_valid = 1'b0; in_data = 64'h0000_0000_0701_0000;
    step();
    pulse_reset();
    check("t6_valid", out_valid, 0);
    check("t6_overflow", overflow, 0);
    check("t6_af", almost_full, 0);
    idle(6);
    check("t6_no_stale", out_valid, 0);

    // T5 full with simultaneous push and pop
    out_ready = 1'b0;
    drive_rows(10, 'h500, -1, 0, 11);
    check("t5_overflow", overflow, 0);
    check("t5_af", almost_full, 1);
    check("t5_head", out_data, 64'h0523_0522_0521_0520);
    drain(n, m);
    check("t5_drain_count", n, 8);

    // Tile-last tagging on a fresh tile
    pulse_reset();
    out_ready = 1'b0;
    drive_rows(8, 'h800, -1, 0, -1);
    drain(n, m);
    check("last_drain_count", n, 8);
`ifdef OUTPUT_LAST_EN
    check("last_mask", m, 8'h88);
`else
    check("last_mask", m, 8'h00);
`endif

    idle(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
